riscv_core_ct: RTL and testbench
================================

# riscv_core_ct

Operand-control and hazard unit for the integer pipeline (ID → EX → MEM → WB). It accepts decoded instructions from ID and tracks in-flight destination registers for the EX, MEM and WB stages. Each cycle it resolves the two source operands from the register file or a forwarding path and registers them as `ct_ex_op1_st2`/`ct_ex_op2_st2` for the EX stage. It stalls ID on an unresolvable hazard, squashes on flush, and performs the register-file writeback.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RADDR_W`, 5, register-index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `id_ct_valid`  in  1  ID presents an instruction.
- `id_ct_rs1`, `id_ct_rs2`  in  RADDR_W each  source register indices.
- `id_ct_rd`  in  RADDR_W  destination register index.
- `id_ct_rd_we`  in  1  instruction writes `rd`.
- `id_ct_is_load`  in  1  instruction is a load.
- `rf_ct_rs1_data`, `rf_ct_rs2_data`  in  XLEN each  register-file read data, combinational on `id_ct_rs1`/`id_ct_rs2`.
- `ex_mem_result`  in  XLEN  registered EX result; valid while the producing instruction is in MEM.
- `mem_ct_rdata`  in  XLEN  load data; valid while the load is in MEM.
- `ct_flush`  in  1  squash the instruction presented by ID this cycle.
- `ct_id_stall`  out  1  ID must hold; combinational.
- `ct_ex_valid`  out  1  EX holds a real instruction, not a bubble.
- `ct_ex_op1_st2`, `ct_ex_op2_st2`  out  XLEN each  resolved operands for EX.
- `ct_rf_we`  out  1  register-file write enable.
- `ct_rf_waddr`  out  RADDR_W  register-file write address.
- `ct_rf_wdata`  out  XLEN  register-file write data.

## Operation
- The block holds a stage record {valid, rd, we, is_load} for each of EX, MEM and WB. WB also holds `wb_data`.
- **Hazard:** a source `rsN` (N = 1, 2) is hazardous when `rsN == EX.rd`, `EX.valid`, `EX.we` and `rsN != 0`.
  - `ct_id_stall = id_ct_valid & ~ct_flush & (hazard on rs1 | hazard on rs2)`.
  - Both sources are always checked; ID decodes unused fields as `x0`.
- **Accept:** the presented instruction is accepted when `id_ct_valid & ~ct_id_stall & ~ct_flush`.
- **Operand resolution at accept**, per source, in priority order:
  1. `rsN == 0` → 0.
  2. MEM match (valid, we, same rd) → `mem_ct_rdata` if `MEM.is_load`, else `ex_mem_result`.
  3. WB match → `wb_data`.
  4. Otherwise → `rf_ct_rsN_data`.
- **Pipeline advance:** every cycle, unconditionally, WB ← MEM and MEM ← EX. EX ← the accepted instruction, or a bubble (valid = 0) if none is accepted.
- **WB data:** `wb_data` captures the MEM-stage value, `mem_ct_rdata` if `MEM.is_load`, else `ex_mem_result`.
- **Writeback:**
  - `ct_rf_we = WB.valid & WB.we & (WB.rd != 0)`.
  - `ct_rf_waddr = WB.rd`; `ct_rf_wdata = wb_data`.
- **Operand registers:** `ct_ex_op1_st2`/`ct_ex_op2_st2` load only on accept and hold their value during bubbles.
- **Flush:** the presented instruction is dropped. It is not stalled, and a bubble enters EX. Instructions already in EX, MEM and WB complete normally.
- **Max stall length:** a single EX-stage dependency stalls exactly one cycle, because the producer has then moved to MEM and is forwarded from there. Loads incur no extra penalty.

## Timing
- **Reset:** all stage valids = 0; operand registers = 0; `wb_data` = 0. Consequently `ct_ex_valid` = 0, `ct_rf_we` = 0, `ct_rf_waddr` = 0, `ct_rf_wdata` = 0, and `ct_id_stall` = 0.
- **Reset mid-operation:** all in-flight state is discarded immediately. No writeback occurs after `rstn` falls.
- **Latency:** an instruction accepted in cycle T is in EX at T+1 (operands valid, `ct_ex_valid` = 1), in MEM at T+2, and in WB at T+3 (`ct_rf_we` asserted during T+3).
- **Same-cycle WB write and ID read of the same register:** forwarding from `wb_data` covers it. The register file has no write-through requirement.
- **Same-cycle flush and stall:** flush wins, `ct_id_stall` = 0, and the instruction is dropped.
- **Combinational stall:** `ct_id_stall` depends only on the registered EX record and the ID inputs, so there is no loop through EX.

## Test plan
- **Back-to-back dependency:** accept rd = x1 (EX produces 5). Next cycle present rs1 = x1 → `ct_id_stall` = 1 for exactly one cycle, a bubble enters EX (`ct_ex_valid` = 0), then accept with `ct_ex_op1_st2` = 5.
- **Load forward:** load x2 (`mem_ct_rdata` = 0xDEADBEEF in MEM), followed by one independent instruction, then rs2 = x2 → no stall, `ct_ex_op2_st2` = 0xDEADBEEF.
- **WB priority:** x3 in WB with `wb_data` = 7, `rf_ct_rs1_data` = 0 → `ct_ex_op1_st2` = 7. With x3 in both MEM (value 9) and WB (value 7) → `ct_ex_op1_st2` = 9.
- **x0:** rd = x0 writer in EX, next rs1 = x0 → no stall, operand 0. When that writer reaches WB, `ct_rf_we` = 0.
- **Flush:** flush asserted while an instruction is stalled → stall drops, next cycle `ct_ex_valid` = 0, and the older EX instruction still writes back 2 cycles later.
- **Reset:** `rstn` low with 3 instructions in flight → all outputs 0 asynchronously. After release, no `ct_rf_we` pulse occurs.

Source files
------------

// File: rtl/riscv_core_ct.sv
// Operand-control and hazard unit: tracks EX/MEM/WB destination records, resolves
// ID source operands via forwarding, stalls on EX-stage dependencies, drives RF writeback.
module riscv_core_ct #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               id_ct_valid,
  input  logic [RADDR_W-1:0] id_ct_rs1,
  input  logic [RADDR_W-1:0] id_ct_rs2,
  input  logic [RADDR_W-1:0] id_ct_rd,
  input  logic               id_ct_rd_we,
  input  logic               id_ct_is_load,
  input  logic [XLEN-1:0]    rf_ct_rs1_data,
  input  logic [XLEN-1:0]    rf_ct_rs2_data,
  input  logic [XLEN-1:0]    ex_mem_result,
  input  logic [XLEN-1:0]    mem_ct_rdata,
  input  logic               ct_flush,
  output logic               ct_id_stall,
  output logic               ct_ex_valid,
  output logic [XLEN-1:0]    ct_ex_op1_st2,
  output logic [XLEN-1:0]    ct_ex_op2_st2,
  output logic               ct_rf_we,
  output logic [RADDR_W-1:0] ct_rf_waddr,
  output logic [XLEN-1:0]    ct_rf_wdata
);

  // Handshake: ID holds its instruction while ct_id_stall is high; an instruction
  // moves to EX only when id_ct_valid & ~ct_id_stall & ~ct_flush.
  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic               is_load;
  } stage_t;

  stage_t            ex_q, mem_q, wb_q, ex_d;
  logic [XLEN-1:0]   wb_data_q;
  logic [XLEN-1:0]   op1_q, op2_q, op1_d, op2_d;
  logic [XLEN-1:0]   mem_val;
  logic              hz1, hz2, accept;

  // Value the MEM-stage instruction will write: load data or the ALU result.
  assign mem_val = mem_q.is_load ? mem_ct_rdata : ex_mem_result;

  function automatic logic [XLEN-1:0] resolve(
    input logic [RADDR_W-1:0] rs,
    input logic [XLEN-1:0]    rf_data,
    input stage_t             mem_s,
    input stage_t             wb_s,
    input logic [XLEN-1:0]    mem_v,
    input logic [XLEN-1:0]    wb_v
  );
    logic [XLEN-1:0] r;
    if (rs == '0)                                          r = '0;
    else if (mem_s.valid && mem_s.we && (mem_s.rd == rs))  r = mem_v;
    else if (wb_s.valid && wb_s.we && (wb_s.rd == rs))     r = wb_v;
    else                                                   r = rf_data;
    return r;
  endfunction

  // Only the EX stage can be unresolvable: its result is not yet available.
  assign hz1 = ex_q.valid && ex_q.we && (id_ct_rs1 == ex_q.rd) && (id_ct_rs1 != '0);
  assign hz2 = ex_q.valid && ex_q.we && (id_ct_rs2 == ex_q.rd) && (id_ct_rs2 != '0);

  assign ct_id_stall = id_ct_valid & ~ct_flush & (hz1 | hz2);
  assign accept      = id_ct_valid & ~ct_id_stall & ~ct_flush;

  always_comb begin
    ex_d  = '0;
    op1_d = op1_q;
    op2_d = op2_q;
    if (accept) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_ct_rd;
      ex_d.we      = id_ct_rd_we;
      ex_d.is_load = id_ct_is_load;
      op1_d = resolve(id_ct_rs1, rf_ct_rs1_data, mem_q, wb_q, mem_val, wb_data_q);
      op2_d = resolve(id_ct_rs2, rf_ct_rs2_data, mem_q, wb_q, mem_val, wb_data_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      wb_data_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      wb_data_q <= mem_val;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
    end
  end

  assign ct_ex_valid   = ex_q.valid;
  assign ct_ex_op1_st2 = op1_q;
  assign ct_ex_op2_st2 = op2_q;
  assign ct_rf_we      = wb_q.valid & wb_q.we & (wb_q.rd != '0);
  assign ct_rf_waddr   = wb_q.rd;
  assign ct_rf_wdata   = wb_data_q;

endmodule

// File: tb/tb_riscv_core_ct.sv
// Bench for riscv_core_ct: instruction-level model of the in-flight window and
// register file, checked every cycle, plus hand-computed literal expectations.
module tb_riscv_core_ct;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk, rstn;
  logic            id_ct_valid, id_ct_rd_we, id_ct_is_load, ct_flush;
  logic [RW-1:0]   id_ct_rs1, id_ct_rs2, id_ct_rd;
  logic [XLEN-1:0] rf_ct_rs1_data, rf_ct_rs2_data, ex_mem_result, mem_ct_rdata;
  logic            ct_id_stall, ct_ex_valid, ct_rf_we;
  logic [XLEN-1:0] ct_ex_op1_st2, ct_ex_op2_st2, ct_rf_wdata;
  logic [RW-1:0]   ct_rf_waddr;

  riscv_core_ct #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clk(clk), .rstn(rstn),
    .id_ct_valid(id_ct_valid), .id_ct_rs1(id_ct_rs1), .id_ct_rs2(id_ct_rs2),
    .id_ct_rd(id_ct_rd), .id_ct_rd_we(id_ct_rd_we), .id_ct_is_load(id_ct_is_load),
    .rf_ct_rs1_data(rf_ct_rs1_data), .rf_ct_rs2_data(rf_ct_rs2_data),
    .ex_mem_result(ex_mem_result), .mem_ct_rdata(mem_ct_rdata), .ct_flush(ct_flush),
    .ct_id_stall(ct_id_stall), .ct_ex_valid(ct_ex_valid),
    .ct_ex_op1_st2(ct_ex_op1_st2), .ct_ex_op2_st2(ct_ex_op2_st2),
    .ct_rf_we(ct_rf_we), .ct_rf_waddr(ct_rf_waddr), .ct_rf_wdata(ct_rf_wdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: in-flight instructions by age (0 = EX, 1 = MEM, 2 = WB), each carrying its result
  typedef struct {
    logic          valid;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
    logic [31:0]   val;
  } rec_t;

  rec_t        slot[3];
  logic [31:0] rf[32];
  logic [31:0] m_op1, m_op2;
  logic [31:0] cur_res;
  logic        dut_stall;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) slot[i] = '{1'b0, '0, 1'b0, 1'b0, 32'h0};
    m_op1 = '0;
    m_op2 = '0;
  endtask

  function automatic logic [31:0] model_op(input logic [RW-1:0] rs);
    if (rs == 0) return 32'h0;
    if (slot[1].valid && slot[1].we && slot[1].rd == rs) return slot[1].val;
    if (slot[2].valid && slot[2].we && slot[2].rd == rs) return slot[2].val;
    return rf[rs];
  endfunction

  // driver: present an instruction; MEM-stage data comes from the model's MEM occupant
  task automatic drive(input logic v, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                       input logic [RW-1:0] d, input logic w, input logic l,
                       input logic [31:0] res, input logic fl);
    id_ct_valid = v; id_ct_rs1 = r1; id_ct_rs2 = r2; id_ct_rd = d;
    id_ct_rd_we = w; id_ct_is_load = l; ct_flush = fl; cur_res = res;
    rf_ct_rs1_data = rf[r1];
    rf_ct_rs2_data = rf[r2];
    if (slot[1].valid && slot[1].ld) begin
      mem_ct_rdata  = slot[1].val;
      ex_mem_result = $urandom;
    end else begin
      ex_mem_result = slot[1].valid ? slot[1].val : $urandom;
      mem_ct_rdata  = $urandom;
    end
  endtask

  // compare at negedge, then advance the model past the next rising edge
  task automatic finish_cycle(output logic e_stall);
    logic        e_acc, e_we;
    logic [31:0] n1, n2;
    @(negedge clk);
    dut_stall = ct_id_stall;
    e_stall = id_ct_valid && !ct_flush && slot[0].valid && slot[0].we &&
              ((id_ct_rs1 == slot[0].rd && id_ct_rs1 != 0) ||
               (id_ct_rs2 == slot[0].rd && id_ct_rs2 != 0));
    e_acc = id_ct_valid && !e_stall && !ct_flush;
    e_we  = slot[2].valid && slot[2].we && slot[2].rd != 0;
    chk("stall", ct_id_stall, e_stall);
    chk("ex_valid", ct_ex_valid, slot[0].valid);
    chk("op1", ct_ex_op1_st2, m_op1);
    chk("op2", ct_ex_op2_st2, m_op2);
    chk("rf_we", ct_rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", ct_rf_waddr, slot[2].rd);
      chk("rf_wdata", ct_rf_wdata, slot[2].val);
    end
    n1 = model_op(id_ct_rs1);
    n2 = model_op(id_ct_rs2);
    @(posedge clk);
    #1;
    if (e_we) rf[slot[2].rd] = slot[2].val;
    slot[2] = slot[1];
    slot[1] = slot[0];
    if (e_acc && rstn) begin
      slot[0] = '{1'b1, id_ct_rd, id_ct_rd_we, id_ct_is_load, cur_res};
      m_op1 = n1;
      m_op2 = n2;
    end else begin
      slot[0] = '{1'b0, '0, 1'b0, 1'b0, 32'h0};
    end
  endtask

  task automatic cyc(input logic v, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                     input logic [RW-1:0] d, input logic w, input logic l,
                     input logic [31:0] res, input logic fl, output logic st);
    drive(v, r1, r2, d, w, l, res, fl);
    finish_cycle(st);
  endtask

  task automatic idle();
    logic st;
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, st);
  endtask

  initial begin
    logic st;
    int   tries;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h0;
    rf[3] = 32'h0;
    model_reset();
    rstn = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    chk("rst_ex_valid", ct_ex_valid, 0);
    chk("rst_rf_we", ct_rf_we, 0);
    chk("rst_waddr", ct_rf_waddr, 0);
    chk("rst_wdata", ct_rf_wdata, 0);
    chk("rst_op1", ct_ex_op1_st2, 0);
    chk("rst_stall", ct_id_stall, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // back-to-back dependency: one-cycle stall, then forwarded from MEM
    cyc(1, 0, 0, 1, 1, 0, 32'd5, 0, st);
    cyc(1, 1, 0, 2, 1, 0, 32'h22, 0, st);
    chk("b2b_stall_seen", dut_stall, 1);
    chk("b2b_bubble", ct_ex_valid, 0);
    cyc(1, 1, 0, 2, 1, 0, 32'h22, 0, st);
    chk("b2b_stall_gone", dut_stall, 0);
    chk("b2b_op1", ct_ex_op1_st2, 32'd5);
    chk("b2b_valid", ct_ex_valid, 1);

    // load forward after one independent instruction
    cyc(1, 0, 0, 2, 1, 1, 32'hDEADBEEF, 0, st);
    cyc(1, 0, 0, 4, 1, 0, 32'h44, 0, st);
    cyc(1, 0, 2, 5, 1, 0, 32'h55, 0, st);
    chk("ld_no_stall", dut_stall, 0);
    chk("ld_op2", ct_ex_op2_st2, 32'hDEADBEEF);

    // WB forward, then MEM priority over WB
    cyc(1, 0, 0, 3, 1, 0, 32'd7, 0, st);
    cyc(1, 0, 0, 6, 1, 0, 32'h66, 0, st);
    cyc(1, 0, 0, 7, 1, 0, 32'h77, 0, st);
    cyc(1, 3, 0, 9, 1, 0, 32'h99, 0, st);
    chk("wb_op1", ct_ex_op1_st2, 32'd7);
    cyc(1, 0, 0, 3, 1, 0, 32'd7, 0, st);
    cyc(1, 0, 0, 3, 1, 0, 32'd9, 0, st);
    cyc(1, 0, 0, 10, 1, 0, 32'hAA, 0, st);
    cyc(1, 3, 0, 11, 1, 0, 32'hBB, 0, st);
    chk("mem_prio_op1", ct_ex_op1_st2, 32'd9);

    // x0 writer: no stall, zero operand, no writeback
    cyc(1, 0, 0, 0, 1, 0, 32'h55, 0, st);
    cyc(1, 0, 0, 11, 1, 0, 32'hB1, 0, st);
    chk("x0_no_stall", dut_stall, 0);
    chk("x0_op1", ct_ex_op1_st2, 32'h0);
    idle();
    chk("x0_no_we", ct_rf_we, 0);

    // flush while stalled: stall drops, bubble, older producer still retires
    cyc(1, 0, 0, 8, 1, 0, 32'h88, 0, st);
    drive(1, 8, 0, 12, 1, 0, 32'hCC, 0);
    #1;
    chk("fl_stall_before", ct_id_stall, 1);
    ct_flush = 1'b1;
    #1;
    chk("fl_stall_after", ct_id_stall, 0);
    finish_cycle(st);
    chk("fl_bubble", ct_ex_valid, 0);
    idle();
    chk("fl_wb_we", ct_rf_we, 1);
    chk("fl_wb_addr", ct_rf_waddr, 8);
    chk("fl_wb_data", ct_rf_wdata, 32'h88);

    // mixed traffic over a small register set; a stalled instruction is re-presented
    for (int i = 0; i < 40; i++) begin
      logic [RW-1:0] r1, r2, d;
      logic          w, l, fl;
      logic [31:0]   res;
      r1 = 5'($urandom_range(0, 4)); r2 = 5'($urandom_range(0, 4));
      d  = 5'($urandom_range(0, 4)); w  = 1'($urandom_range(0, 3) != 0);
      l  = 1'($urandom_range(0, 2) == 0); fl = 1'($urandom_range(0, 7) == 0);
      res = $urandom;
      tries = 0;
      do begin
        cyc(1'($urandom_range(0, 5) != 0), r1, r2, d, w, l, res, fl, st);
        tries++;
      end while (st && tries < 3);
      if (st) chk("stall_bound", 1, 0);
    end
    idle(); idle(); idle();

    // reset with three instructions in flight
    cyc(1, 0, 0, 13, 1, 0, 32'hD13, 0, st);
    cyc(1, 0, 0, 14, 1, 1, 32'hD14, 0, st);
    cyc(1, 0, 0, 15, 1, 0, 32'hD15, 0, st);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ex_valid", ct_ex_valid, 0);
    chk("mid_rst_rf_we", ct_rf_we, 0);
    chk("mid_rst_waddr", ct_rf_waddr, 0);
    chk("mid_rst_wdata", ct_rf_wdata, 0);
    chk("mid_rst_op1", ct_ex_op1_st2, 0);
    chk("mid_rst_op2", ct_ex_op2_st2, 0);
    model_reset();
    idle(); idle();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
